// File: rtl/branch_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_fwd_ctrl
// Purpose  : Forwarding and load-hazard controller for the ID-stage branch
//            comparator of a 5-stage MIPS pipeline. It keeps a three-entry
//            shadow of the destinations in EX, MEM and WB. It produces the
//            operand select codes and a stall request.
// Ports    : clk, rst_n (sync, active-low)
//            id_valid, id_is_branch, id_uses_rt, id_rs, id_rt, id_dst,
//            id_we, id_is_load      - ID-stage instruction description
//            cmpsrc_a, cmpsrc_b     - 00 regfile, 01 ID/EX, 10 EX/MEM, 11 MEM/WB
//            stall                  - freeze PC and IF/ID, bubble into EX
//            BRANCH_FWD_STATS_EN adds: stats_clr, stall_cycles, fwd_events
// Revision : 1.0 - initial release
// ============================================================================
module branch_fwd_ctrl #(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_is_branch,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_we,
   input  logic             id_is_load,
`ifdef BRANCH_FWD_STATS_EN
   input  logic             stats_clr,
   output logic [15:0]      stall_cycles,
   output logic [15:0]      fwd_events,
`endif
   output logic [1:0]       cmpsrc_a,
   output logic [1:0]       cmpsrc_b,
   output logic             stall
);

   localparam logic [REG_W-1:0] ZERO_IDX  = REG_W'(ZERO_REG);

   localparam logic [1:0]       SEL_RF    = 2'b00;
   localparam logic [1:0]       SEL_IDEX  = 2'b01;
   localparam logic [1:0]       SEL_EXMEM = 2'b10;
   localparam logic [1:0]       SEL_MEMWB = 2'b11;

   localparam logic [1:0]       S_RUN     = 2'd0;
   localparam logic [1:0]       S_STALL1  = 2'd1;
   localparam logic [1:0]       S_STALL2  = 2'd2;

   // Shadow pipeline entries {dst, we, load}
   logic [REG_W-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
   logic             ex_we_q,  mem_we_q,  wb_we_q;
   logic             ex_ld_q,  mem_ld_q,  wb_ld_q;
   logic [REG_W-1:0] ex_dst_d;
   logic             ex_we_d, ex_ld_d;

   logic [1:0]       state_q, state_d;
   logic [1:0]       w_state;
   logic             w_stall;
   logic             w_issue;
   logic             w_br;

   // Operand 0 is rs (A), operand 1 is rt (B)
   logic [1:0][REG_W-1:0] w_opnd;
   logic [1:0][1:0]       w_sel;
   logic [1:0]            w_haz_ex;
   logic [1:0]            w_haz_mem;
   logic [1:0]            w_live;
   logic                  w_hz_ex_any;
   logic                  w_hz_mem_any;
   logic                  w_haz_rule;

   assign w_opnd[0] = id_rs;
   assign w_opnd[1] = id_rt;

   for (genvar g = 0; g < 2; g++) begin : g_opnd
      logic w_nz, w_m_ex, w_m_mem, w_m_wb;
      assign w_nz    = (w_opnd[g] != ZERO_IDX);
      assign w_m_ex  = w_nz & ex_we_q  & (ex_dst_q  == w_opnd[g]);
      assign w_m_mem = w_nz & mem_we_q & (mem_dst_q == w_opnd[g]);
      assign w_m_wb  = w_nz & wb_we_q  & (wb_dst_q  == w_opnd[g]);
      // A load in EX/MEM has no data yet: it shadows older producers and
      // shows up as a hazard instead of a select.
      assign w_haz_ex[g]  = w_m_ex  & ex_ld_q;
      assign w_haz_mem[g] = w_m_mem & mem_ld_q;
      assign w_sel[g] = (w_m_ex  & ~ex_ld_q)  ? SEL_IDEX  :
                        (w_m_mem & ~mem_ld_q) ? SEL_EXMEM :
                        w_m_wb                ? SEL_MEMWB : SEL_RF;
   end

   assign w_br         = id_valid & id_is_branch;
   assign w_live       = {id_uses_rt, 1'b1};
   assign w_hz_ex_any  = w_br & |(w_haz_ex  & w_live);
   assign w_hz_mem_any = w_br & |(w_haz_mem & w_live);
   assign w_haz_rule   = w_hz_ex_any | w_hz_mem_any;

   // ------------------------------------------------------------------------
   // Hazard FSM. state_q holds the stall cycles still owed after the current
   // one; in RUN the current state is decided by the live hazard so the
   // stall appears in the same cycle the dependency is seen.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      w_state = S_RUN;
      state_d = S_RUN;
      case (state_q)
         S_RUN: begin
            if (w_hz_ex_any)       w_state = S_STALL2;
            else if (w_hz_mem_any) w_state = S_STALL1;
            else                   w_state = S_RUN;
         end
         S_STALL2, S_STALL1: w_state = state_q;
         default:            w_state = S_RUN;
      endcase
      case (w_state)
         S_STALL2: state_d = S_STALL1;
         default:  state_d = S_RUN;
      endcase
   end

   always_comb begin
      w_stall  = (w_state != S_RUN);
      cmpsrc_a = w_sel[0];
      cmpsrc_b = id_uses_rt ? w_sel[1] : SEL_RF;
   end

   assign stall = w_stall;

   // ------------------------------------------------------------------------
   // Shadow pipeline: a stalled or invalid ID slot enters EX as a bubble.
   // ------------------------------------------------------------------------
   assign w_issue  = id_valid & ~w_stall;
   assign ex_dst_d = w_issue ? id_dst     : '0;
   assign ex_we_d  = w_issue & id_we;
   assign ex_ld_d  = w_issue & id_is_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_dst_q  <= '0;
         ex_we_q   <= 1'b0;
         ex_ld_q   <= 1'b0;
         mem_dst_q <= '0;
         mem_we_q  <= 1'b0;
         mem_ld_q  <= 1'b0;
         wb_dst_q  <= '0;
         wb_we_q   <= 1'b0;
         wb_ld_q   <= 1'b0;
      end else begin
         wb_dst_q  <= mem_dst_q;
         wb_we_q   <= mem_we_q;
         wb_ld_q   <= mem_ld_q;
         mem_dst_q <= ex_dst_q;
         mem_we_q  <= ex_we_q;
         mem_ld_q  <= ex_ld_q;
         ex_dst_q  <= ex_dst_d;
         ex_we_q   <= ex_we_d;
         ex_ld_q   <= ex_ld_d;
      end
   end

`ifdef BRANCH_FWD_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] fwd_cnt_q;
   logic        w_fwd_evt;

   assign w_fwd_evt = w_br & ~w_stall & ((cmpsrc_a != SEL_RF) | (cmpsrc_b != SEL_RF));

   // Clear has priority over a same-cycle increment; counts saturate.
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         if (w_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (w_fwd_evt && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_q   <= fwd_cnt_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign fwd_events   = fwd_cnt_q;
`else
   logic w_unused;
   assign w_unused = wb_ld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_fwd_ctrl
// Purpose  : Directed scoreboard bench for branch_fwd_ctrl. The driver pushes
//            hand-computed expectations; a negedge monitor pops and compares.
//            Stats counters are checked when BRANCH_FWD_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_is_branch, id_uses_rt, id_we, id_is_load;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic        stats_clr;
   logic [1:0]  cmpsrc_a, cmpsrc_b;
   logic        stall;
`ifdef BRANCH_FWD_STATS_EN
   logic [15:0] stall_cycles, fwd_events;
`endif

   always #5 clk = ~clk;

   branch_fwd_ctrl #(.REG_W(5), .ZERO_REG(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_is_branch (id_is_branch),
      .id_uses_rt   (id_uses_rt),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_dst       (id_dst),
      .id_we        (id_we),
      .id_is_load   (id_is_load),
`ifdef BRANCH_FWD_STATS_EN
      .stats_clr    (stats_clr),
      .stall_cycles (stall_cycles),
      .fwd_events   (fwd_events),
`endif
      .cmpsrc_a     (cmpsrc_a),
      .cmpsrc_b     (cmpsrc_b),
      .stall        (stall)
   );

   // mask bits: [0] stall, [1] cmpsrc_a, [2] cmpsrc_b, [3] stall_cycles, [4] fwd_events
   localparam logic [4:0] M_ST  = 5'b00001;
   localparam logic [4:0] M_SEL = 5'b00111;
   localparam logic [4:0] M_STS = 5'b11001;
   localparam logic [4:0] M_ALL = 5'b11111;

   typedef struct packed {
      int          tag;
      logic [4:0]  m;
      logic [1:0]  a;
      logic [1:0]  b;
      logic        s;
      logic [15:0] sc;
      logic [15:0] fe;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   tag_cnt  = 0;
   logic fsm_chk  = 1'b0;

   // ---------------- driver helpers ----------------
   task automatic drive(input logic v, input logic br, input logic urt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic we, input logic ld);
      @(posedge clk); #1;
      id_valid = v; id_is_branch = br; id_uses_rt = urt;
      id_rs = rs; id_rt = rt; id_dst = dst; id_we = we; id_is_load = ld;
   endtask

   task automatic lw(input logic [4:0] d);   drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, d, 1'b1, 1'b1); endtask
   task automatic alu(input logic [4:0] d);  drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, d, 1'b1, 1'b0); endtask
   task automatic br(input logic [4:0] rs, input logic [4:0] rt, input logic urt);
      drive(1'b1, 1'b1, urt, rs, rt, 5'd0, 1'b0, 1'b0);
   endtask
   task automatic nop();  drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); endtask
   task automatic hold(); @(posedge clk); #1; endtask

   task automatic expect_out(input logic [4:0] m, input logic [1:0] a, input logic [1:0] b,
                             input logic s, input logic [15:0] sc, input logic [15:0] fe);
      exp_t e;
      tag_cnt++;
      e.tag = tag_cnt; e.m = m; e.a = a; e.b = b; e.s = s; e.sc = sc; e.fe = fe;
      q.push_back(e);
   endtask

   task automatic exp_sel(input logic [1:0] a, input logic [1:0] b, input logic s);
      expect_out(M_SEL, a, b, s, 16'd0, 16'd0);
   endtask
   task automatic exp_st(input logic s); expect_out(M_ST, 2'b00, 2'b00, s, 16'd0, 16'd0); endtask
   task automatic flush(); for (int i = 0; i < 3; i++) begin nop(); exp_st(1'b0); end endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.m[0]) begin
               checks++;
               if (stall !== e.s) begin
                  failures++;
                  $display("FAIL stall#%0d got=%0b want=%0b", e.tag, stall, e.s);
               end
            end
            if (e.m[1]) begin
               checks++;
               if (cmpsrc_a !== e.a) begin
                  failures++;
                  $display("FAIL cmpsrc_a#%0d got=%02b want=%02b", e.tag, cmpsrc_a, e.a);
               end
            end
            if (e.m[2]) begin
               checks++;
               if (cmpsrc_b !== e.b) begin
                  failures++;
                  $display("FAIL cmpsrc_b#%0d got=%02b want=%02b", e.tag, cmpsrc_b, e.b);
               end
            end
`ifdef BRANCH_FWD_STATS_EN
            if (e.m[3]) begin
               checks++;
               if (stall_cycles !== e.sc) begin
                  failures++;
                  $display("FAIL stall_cycles#%0d got=%0d want=%0d", e.tag, stall_cycles, e.sc);
               end
            end
            if (e.m[4]) begin
               checks++;
               if (fwd_events !== e.fe) begin
                  failures++;
                  $display("FAIL fwd_events#%0d got=%0d want=%0d", e.tag, fwd_events, e.fe);
               end
            end
`endif
         end
      end
   end

   // The hazard FSM must always agree with the combinational hazard rule.
   always @(negedge clk) begin
      if (fsm_chk) begin
         checks++;
         if (stall !== dut.w_haz_rule) begin
            failures++;
            $display("FAIL fsm_vs_rule t=%0t stall=%0b rule=%0b", $time, stall, dut.w_haz_rule);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired queue=%0d", q.size());
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; stats_clr = 1'b0;
      id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rt = 1'b1;
      id_rs = 5'd8; id_rt = 5'd9; id_dst = 5'd0; id_we = 1'b0; id_is_load = 1'b0;

      // Reset held two cycles with a branch in ID
      hold(); fsm_chk = 1'b1; expect_out(M_ALL, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
      hold(); exp_sel(2'b00, 2'b00, 1'b0);
      nop(); rst_n = 1'b1; exp_st(1'b0);

      // lw $8 ; beq $8,$9 -> 2-cycle stall, then A from MEM/WB
      lw(5'd8);              exp_st(1'b0);
      br(5'd8, 5'd9, 1'b1);  exp_sel(2'b00, 2'b00, 1'b1);
      hold();                exp_sel(2'b00, 2'b00, 1'b1);
      hold();                exp_sel(2'b11, 2'b00, 1'b0);
      flush();

      // add $8 ; add $9 ; beq $8,$9
      alu(5'd8);             exp_st(1'b0);
      alu(5'd9);             exp_st(1'b0);
      br(5'd8, 5'd9, 1'b1);  exp_sel(2'b10, 2'b01, 1'b0);
      flush();

      // ALU producer distance 1..4, single-operand branch (rt ignored)
      alu(5'd10); br(5'd10, 5'd10, 1'b0); exp_sel(2'b01, 2'b00, 1'b0);
      flush();
      alu(5'd10); nop(); br(5'd10, 5'd10, 1'b0); exp_sel(2'b10, 2'b00, 1'b0);
      flush();
      alu(5'd10); nop(); nop(); br(5'd10, 5'd10, 1'b0); exp_sel(2'b11, 2'b00, 1'b0);
      flush();
      alu(5'd10); nop(); nop(); nop(); br(5'd10, 5'd10, 1'b0); exp_sel(2'b00, 2'b00, 1'b0);
      flush();

      // Register zero is never forwarded nor hazarded
      alu(5'd0); br(5'd0, 5'd0, 1'b1); exp_sel(2'b00, 2'b00, 1'b0);
      lw(5'd0);  br(5'd0, 5'd0, 1'b1); exp_sel(2'b00, 2'b00, 1'b0);
      flush();

      // lw $8 ; lw $9 ; beq $8,$9 -> stall 2, release A=00 B=11
      lw(5'd8);              exp_st(1'b0);
      lw(5'd9);              exp_st(1'b0);
      br(5'd8, 5'd9, 1'b1);  exp_sel(2'b00, 2'b00, 1'b1);
      hold();                exp_sel(2'b11, 2'b00, 1'b1);
      hold();                exp_sel(2'b00, 2'b11, 1'b0);
      flush();

      // Load two ahead -> 1-cycle stall
      lw(5'd8); alu(5'd11);
      br(5'd8, 5'd9, 1'b1);  exp_sel(2'b00, 2'b00, 1'b1);
      hold();                exp_sel(2'b11, 2'b00, 1'b0);
      flush();

      // Load on rt but rt not live -> no stall
      lw(5'd9); br(5'd8, 5'd9, 1'b0); exp_sel(2'b00, 2'b00, 1'b0);
      flush();

      // Non-branch consumer and invalid branch never stall
      lw(5'd8); drive(1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd12, 1'b1, 1'b0); exp_st(1'b0);
      flush();
      lw(5'd8); drive(1'b0, 1'b1, 1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0); exp_st(1'b0);
      flush();

      // Reset dropped in the first stall cycle aborts the stall
      lw(5'd8);
      br(5'd8, 5'd9, 1'b1); rst_n = 1'b0; exp_sel(2'b00, 2'b00, 1'b1);
      hold(); rst_n = 1'b1; expect_out(M_ALL, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);

      // Unreset 2-cycle stall, clear-vs-increment priority, forward event
      lw(5'd8);              expect_out(M_STS, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
      br(5'd8, 5'd9, 1'b1);  expect_out(M_ALL, 2'b00, 2'b00, 1'b1, 16'd0, 16'd0);
      hold();                expect_out(M_ALL, 2'b00, 2'b00, 1'b1, 16'd1, 16'd0);
      hold(); stats_clr = 1'b1; expect_out(M_ALL, 2'b11, 2'b00, 1'b0, 16'd2, 16'd0);
      nop();  stats_clr = 1'b0; expect_out(M_STS, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
      alu(5'd8);             expect_out(M_STS, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
      br(5'd8, 5'd9, 1'b1);  expect_out(M_ALL, 2'b01, 2'b00, 1'b0, 16'd0, 16'd0);
      nop();                 expect_out(M_STS, 2'b00, 2'b00, 1'b0, 16'd0, 16'd1);
      flush();

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
